// File: rtl/cdce62002_pkg.sv
// Shared definitions for the CDCE62002 SPI programming and readback engines.
package cdce62002_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam logic [3:0]  CMD_READ = 4'hE;

    typedef enum logic [2:0] {
        RB_IDLE,
        RB_CMD,
        RB_GAP,
        RB_READ,
        RB_FIN
    } rb_state_t;

    // Read command: address in bits [7:4], command nibble in [3:0].
    function automatic logic [WORD_W-1:0] build_read_cmd(input logic [3:0] addr);
        return {24'h0, addr, CMD_READ};
    endfunction

endpackage

// File: rtl/cdce62002_spi_phy.sv
// Bit-level SPI shifter: HALF-cycle clock phases, 32-bit frames, LSB first.
// Transmit frames shift out on spi_clk falls; receive frames shift in on rises.
module cdce62002_spi_phy
    import cdce62002_pkg::*;
#(
    parameter int unsigned HALF = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              tx,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift_en,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              rise,
    output logic              bit_done,
    output logic              frame_done,
    output logic [WORD_W-1:0] rx_data
);

    localparam logic [7:0] HALF_LAST = 8'(HALF - 1);

    logic [7:0]        half_cnt_q;
    logic [4:0]        bit_cnt_q;
    logic [WORD_W-1:0] sr_q;
    logic              sclk_q;
    logic              tx_q;
    logic              phase_end;

    assign phase_end  = shift_en && (half_cnt_q == HALF_LAST);
    assign rise       = phase_end && !sclk_q;
    assign bit_done   = phase_end && sclk_q;
    assign frame_done = bit_done && (bit_cnt_q == 5'd31);

    always_ff @(posedge clk) begin
        if (reset) begin
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            sclk_q     <= 1'b0;
            tx_q       <= 1'b0;
        end else if (load) begin
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= load_data;
            sclk_q     <= 1'b0;
            tx_q       <= tx;
        end else if (shift_en) begin
            if (phase_end) begin
                half_cnt_q <= '0;
                sclk_q     <= !sclk_q;
                if (rise && !tx_q) begin
                    sr_q <= {miso, sr_q[WORD_W-1:1]};
                end
                if (bit_done) begin
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                    // Zeros fill from the top, so MOSI idles low once the frame drains.
                    if (tx_q) begin
                        sr_q <= {1'b0, sr_q[WORD_W-1:1]};
                    end
                end
            end else begin
                half_cnt_q <= half_cnt_q + 8'd1;
            end
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = tx_q & sr_q[0];
    assign rx_data = sr_q;

endmodule

// File: rtl/cdce62002_readback.sv
// CDCE62002 register readback: command frame, LE gap, 32-bit read frame, compare.
module cdce62002_readback
    import cdce62002_pkg::*;
#(
    parameter int unsigned HALF     = 1,
    parameter int unsigned GAP_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        reg_addr,
    input  logic [WORD_W-1:0] expected,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rdata,
    output logic              mismatch,
    output logic              spi_clk,
    output logic              spi_le,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int unsigned GAP_LEN  = GAP_BITS * 2 * HALF;
    localparam logic [16:0] GAP_LAST = 17'(GAP_LEN - 1);

    rb_state_t         state_q;
    logic [16:0]       gap_cnt_q;
    logic [WORD_W-1:0] exp_q;
    logic [WORD_W-1:0] rdata_q;
    logic              le_q;
    logic              busy_q;
    logic              done_q;
    logic              mismatch_q;

    logic              accept;
    logic              gap_last;
    logic              phy_load;
    logic              phy_tx;
    logic              shift_en;
    logic              frame_done;
    logic [WORD_W-1:0] rx_data;

    assign accept   = (state_q == RB_IDLE) && start;
    assign gap_last = (state_q == RB_GAP) && (gap_cnt_q == GAP_LAST);
    assign phy_load = accept || gap_last;
    assign phy_tx   = (state_q == RB_IDLE);
    assign shift_en = (state_q == RB_CMD) || (state_q == RB_READ);

    cdce62002_spi_phy #(.HALF(HALF)) u_phy (
        .clk        (clk),
        .reset      (reset),
        .load       (phy_load),
        .tx         (phy_tx),
        .load_data  (phy_tx ? build_read_cmd(reg_addr) : '0),
        .shift_en   (shift_en),
        .miso       (spi_miso),
        .sclk       (spi_clk),
        .mosi       (spi_mosi),
        .rise       (),
        .bit_done   (),
        .frame_done (frame_done),
        .rx_data    (rx_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RB_IDLE;
            gap_cnt_q  <= '0;
            exp_q      <= '0;
            rdata_q    <= '0;
            le_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RB_IDLE: begin
                    if (start) begin
                        exp_q   <= expected;
                        le_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RB_CMD;
                    end
                end
                RB_CMD: begin
                    if (frame_done) begin
                        le_q      <= 1'b1;
                        gap_cnt_q <= '0;
                        state_q   <= RB_GAP;
                    end
                end
                RB_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        le_q    <= 1'b0;
                        state_q <= RB_READ;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 17'd1;
                    end
                end
                RB_READ: begin
                    if (frame_done) begin
                        le_q       <= 1'b1;
                        done_q     <= 1'b1;
                        rdata_q    <= rx_data;
                        mismatch_q <= (rx_data != exp_q);
                        state_q    <= RB_FIN;
                    end
                end
                RB_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= RB_IDLE;
                end
                default: state_q <= RB_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign mismatch = mismatch_q;
    assign spi_le   = le_q;

endmodule

// File: tb/tb_cdce62002_readback.sv
// Directed bench for cdce62002_readback: default timing instance plus a HALF=3/GAP_BITS=1 instance.
module tb_cdce62002_readback;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start2;
    logic [3:0]  reg_addr;
    logic [31:0] expected;
    logic        miso = 1'b0;

    logic        busy1, done1, mism1, sclk1, le1, mosi1;
    logic        busy2, done2, mism2, sclk2, le2, mosi2;
    logic [31:0] rdata1, rdata2;

    always #5 clk = ~clk;

    cdce62002_readback #(.HALF(1), .GAP_BITS(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .reg_addr(reg_addr), .expected(expected),
        .busy(busy1), .done(done1), .rdata(rdata1), .mismatch(mism1),
        .spi_clk(sclk1), .spi_le(le1), .spi_mosi(mosi1), .spi_miso(miso)
    );

    cdce62002_readback #(.HALF(3), .GAP_BITS(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .reg_addr(reg_addr), .expected(expected),
        .busy(busy2), .done(done2), .rdata(rdata2), .mismatch(mism2),
        .spi_clk(sclk2), .spi_le(le2), .spi_mosi(mosi2), .spi_miso(miso)
    );

    // The device model and monitor follow whichever instance sel picks; the other sits idle.
    logic sel = 1'b0;
    logic m_le, m_clk, m_mosi, m_busy, m_done;
    assign m_le   = sel ? le2   : le1;
    assign m_clk  = sel ? sclk2 : sclk1;
    assign m_mosi = sel ? mosi2 : mosi1;
    assign m_busy = sel ? busy2 : busy1;
    assign m_done = sel ? done2 : done1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] dev_word = '0;
    logic [31:0] cmd_cap  = '0;
    int  rise_cnt = 0, bitidx = 0, total_rises = 0;
    bit  rd_next = 0, in_read = 0;
    logic ple = 1'b1, pclk = 1'b0;

    always @(m_le, m_clk, reset) begin
        if (reset) begin
            rd_next = 0;
            in_read = 0;
            miso    = 1'b0;
        end else begin
            if (ple && !m_le) begin
                in_read  = rd_next;
                rise_cnt = 0;
                bitidx   = 0;
                miso     = in_read ? dev_word[0] : 1'b0;
            end else if (!ple && m_le) begin
                if (rise_cnt == 32) rd_next = !in_read;
                in_read = 0;
                miso    = 1'b0;
            end
            if (!pclk && m_clk) begin
                total_rises++;
                if (!m_le) begin
                    if (!in_read && rise_cnt < 32) cmd_cap[rise_cnt] = m_mosi;
                    rise_cnt++;
                    // Wrong level during the high phase exposes sampling on the wrong edge.
                    if (in_read && bitidx < 32) miso = ~dev_word[bitidx];
                end
            end
            if (pclk && !m_clk && !m_le && in_read) begin
                bitidx++;
                miso = (bitidx < 32) ? dev_word[bitidx] : 1'b0;
            end
        end
        ple  = m_le;
        pclk = m_clk;
    end

    int   acc_cyc = 0, done_cnt = 0, le_viol = 0;
    int   run_len = 0, run_min = 1000, run_max = 0;
    logic prev_busy = 1'b0, prev_le = 1'b1, prev_clk = 1'b0;

    always @(negedge clk) begin
        if (m_busy && !prev_busy) acc_cyc = cyc - 1;
        if (m_done) done_cnt++;
        if (m_le && m_clk) le_viol++;
        if (sel && !m_le) begin
            if (prev_le) run_len = 1;
            else if (m_clk != prev_clk) begin
                if (run_len < run_min) run_min = run_len;
                if (run_len > run_max) run_max = run_len;
                run_len = 1;
            end else run_len++;
        end
        prev_busy = m_busy;
        prev_le   = m_le;
        prev_clk  = m_clk;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!m_done && n < budget);
        chk("done_seen", 32'(m_done), 32'd1);
    endtask

    // Start is high for one cycle; inputs are scrambled right after accept.
    task automatic start_txn(input bit which, input logic [3:0] a, input logic [31:0] e);
        reg_addr = a;
        expected = e;
        if (which) start2 = 1'b1; else start1 = 1'b1;
        tick();
        start1   = 1'b0;
        start2   = 1'b0;
        reg_addr = ~a;
        expected = ~e;
    endtask

    int r0, d0, d1, d2;

    initial begin
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; reg_addr = '0; expected = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_le", 32'(le1), 32'd1);
        chk("rst_sclk", 32'(sclk1), 32'd0);
        chk("rst_mosi", 32'(mosi1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_rdata", rdata1, 32'h0);
        chk("rst_mism", 32'(mism1), 32'd0);
        chk("rst_le2", 32'(le2), 32'd1);

        // Basic read, matching expectation
        dev_word = 32'hB7870061;
        r0 = total_rises;
        start_txn(0, 4'h2, 32'hB7870061);
        chk("busy_after_accept", 32'(busy1), 32'd1);
        wait_done(300);
        chk("t1_latency", 32'(cyc - acc_cyc), 32'd137);
        chk("t1_rdata", rdata1, 32'hB7870061);
        chk("t1_mism", 32'(mism1), 32'd0);
        chk("t1_cmd", cmd_cap, 32'h0000002E);
        chk("t1_busy_at_done", 32'(busy1), 32'd1);
        tick();
        chk("t1_busy_drop", 32'(busy1), 32'd0);
        chk("t1_done_pulse", 32'(done1), 32'd0);
        chk("t1_rises", 32'(total_rises - r0), 32'd64);

        // Same read against a different reference
        start_txn(0, 4'h2, 32'h54200080);
        wait_done(300);
        chk("t2_rdata", rdata1, 32'hB7870061);
        chk("t2_mism", 32'(mism1), 32'd1);
        repeat (5) tick();
        chk("t2_rdata_hold", rdata1, 32'hB7870061);
        chk("t2_mism_hold", 32'(mism1), 32'd1);

        // Start pulses while busy must be ignored
        d0 = done_cnt;
        r0 = total_rises;
        start_txn(0, 4'h2, 32'hB7870061);
        repeat (9) tick();
        start1 = 1'b1; tick(); start1 = 1'b0;
        repeat (89) tick();
        start1 = 1'b1; tick(); start1 = 1'b0;
        wait_done(100);
        chk("t3_latency", 32'(cyc - acc_cyc), 32'd137);
        repeat (200) tick();
        chk("t3_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t3_rises", 32'(total_rises - r0), 32'd64);

        // Reset during the gap aborts; a fresh start then completes
        start_txn(0, 4'h2, 32'hB7870061);
        repeat (69) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_le", 32'(le1), 32'd1);
        chk("abort_sclk", 32'(sclk1), 32'd0);
        chk("abort_rdata", rdata1, 32'h0);
        chk("abort_busy", 32'(busy1), 32'd0);
        repeat (4) tick();
        d0 = done_cnt;
        start_txn(0, 4'h2, 32'h0);
        wait_done(300);
        chk("t4_latency", 32'(cyc - acc_cyc), 32'd137);
        chk("t4_rdata", rdata1, 32'hB7870061);
        chk("t4_mism", 32'(mism1), 32'd1);
        chk("t4_done_count", 32'(done_cnt - d0), 32'd1);

        // Slow instance: HALF=3, GAP_BITS=1
        sel = 1'b1;
        dev_word = 32'h5A5AA5A5;
        r0 = total_rises;
        tick();
        start_txn(1, 4'h9, 32'h5A5AA5A5);
        wait_done(500);
        chk("h3_latency", 32'(cyc - acc_cyc), 32'd391);
        chk("h3_rdata", rdata2, 32'h5A5AA5A5);
        chk("h3_mism", 32'(mism2), 32'd0);
        chk("h3_cmd", cmd_cap, 32'h0000009E);
        chk("h3_phase_min", 32'(run_min), 32'd3);
        chk("h3_phase_max", 32'(run_max), 32'd3);
        chk("h3_rises", 32'(total_rises - r0), 32'd64);
        tick();
        sel = 1'b0;
        tick();

        // Back-to-back with start held high
        dev_word = 32'h13579BDF;
        d0 = done_cnt;
        reg_addr = 4'h4;
        expected = 32'h13579BDF;
        start1 = 1'b1;
        wait_done(300);
        chk("b2b_latency", 32'(cyc - acc_cyc), 32'd137);
        d1 = cyc;
        wait_done(300);
        chk("b2b_gap1", 32'(cyc - d1), 32'd138);
        d2 = cyc;
        tick();
        chk("b2b_busy_low", 32'(busy1), 32'd0);
        tick();
        start1 = 1'b0;
        chk("b2b_busy_again", 32'(busy1), 32'd1);
        wait_done(300);
        chk("b2b_gap2", 32'(cyc - d2), 32'd138);
        chk("b2b_rdata", rdata1, 32'h13579BDF);
        chk("b2b_mism", 32'(mism1), 32'd0);
        repeat (200) tick();
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd3);

        chk("le_sclk_overlap", 32'(le_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
